// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-based stall/flush/redirect/halt control for an N-stage pipeline.
// Define PIPE_FORWARDING_EN to add fwd_a/fwd_b and reduce stalls to the load-use bubble.
module pipeline_hazard_ctrl #(
    parameter int STAGES    = 5,
    parameter int REG_W     = 5,
    parameter int RES_STAGE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 mem_req,
    input  logic [REG_W-1:0]     dec_rs,
    input  logic [REG_W-1:0]     dec_rt,
    input  logic                 dec_use_rs,
    input  logic                 dec_use_rt,
    input  logic [REG_W-1:0]     dec_wsel,
    input  logic                 dec_regwen,
    input  logic                 dec_load,
    input  logic                 redirect,
    input  logic                 wb_halt,
    output logic                 pc_en,
    output logic [STAGES-2:0]    latch_en,
    output logic [STAGES-2:0]    latch_flush,
    output logic                 stall,
    output logic                 halt,
`ifdef PIPE_FORWARDING_EN
    output logic [2:0]           fwd_a,
    output logic [2:0]           fwd_b,
`endif
    output logic [31:0]          stall_cnt
);
    localparam int L = STAGES - 1;
    localparam logic [L-1:0] RMASK = L'((1 << RES_STAGE) - 1);

    logic             sb_v   [1:L-1];
    logic             sb_w   [1:L-1];
    logic [REG_W-1:0] sb_sel [1:L-1];
    logic             ma     [1:L-1];
    logic             mb     [1:L-1];
    logic             freeze, blk, hazard;

    assign freeze = !ihit | (mem_req & !dhit) | halt;
    // a halting instruction blocks the pipeline in the same cycle it is seen
    assign blk = freeze | wb_halt;

    always_comb begin
        for (int k = 1; k <= L - 1; k++) begin
            ma[k] = 1'b0;
            mb[k] = 1'b0;
        end
        for (int k = 1; k <= L - 2; k++) begin
            ma[k] = dec_use_rs && dec_rs != '0 && sb_v[k] && sb_w[k] && sb_sel[k] == dec_rs;
            mb[k] = dec_use_rt && dec_rt != '0 && sb_v[k] && sb_w[k] && sb_sel[k] == dec_rt;
        end
    end

`ifdef PIPE_FORWARDING_EN
    logic sb_ld1;
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = L - 2; k >= 1; k--) begin
            if (ma[k]) fwd_a = 3'(k);
            if (mb[k]) fwd_b = 3'(k);
        end
    end
    assign hazard = sb_ld1 && (fwd_a == 3'd1 || fwd_b == 3'd1);
`else
    logic unused;
    assign unused = dec_load;
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= L - 2; k++)
            hazard = hazard | ma[k] | mb[k];
    end
`endif

    always_comb begin
        pc_en = 1'b0;
        latch_en = '0;
        latch_flush = '0;
        stall = 1'b0;
        if (rst) begin
            latch_flush = '1;
        end else if (!blk) begin
            stall = hazard & !redirect;
            pc_en = !stall;
            latch_en = stall ? ~L'(1) : {L{1'b1}};
            latch_flush = redirect ? RMASK : stall ? L'(2) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
            stall_cnt <= '0;
            for (int k = 1; k <= L - 1; k++) begin
                sb_v[k] <= 1'b0;
                sb_w[k] <= 1'b0;
                sb_sel[k] <= '0;
            end
`ifdef PIPE_FORWARDING_EN
            sb_ld1 <= 1'b0;
`endif
        end else begin
            if (wb_halt && !freeze) halt <= 1'b1;
            if (!blk) begin
                if (stall) stall_cnt <= stall_cnt + 32'd1;
                sb_v[1] <= !latch_flush[1];
                sb_w[1] <= dec_regwen;
                sb_sel[1] <= dec_wsel;
`ifdef PIPE_FORWARDING_EN
                sb_ld1 <= dec_load;
`endif
                for (int k = 2; k <= L - 1; k++) begin
                    sb_v[k] <= sb_v[k-1] & !latch_flush[k];
                    sb_w[k] <= sb_w[k-1];
                    sb_sel[k] <= sb_sel[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a queue-of-writers reference model.
module tb_pipeline_hazard_ctrl;
    localparam int STAGES = 5, REG_W = 5, RES = 3, L = STAGES - 1;
`ifdef PIPE_FORWARDING_EN
    localparam int ADD_ST = 0, LD_ST = 1;
`else
    localparam int ADD_ST = 2, LD_ST = 2;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic ihit, dhit, mem_req, dec_use_rs, dec_use_rt, dec_regwen, dec_load, redirect, wb_halt;
    logic [REG_W-1:0] dec_rs, dec_rt, dec_wsel;
    logic pc_en, stall, halt;
    logic [L-1:0] latch_en, latch_flush;
    logic [31:0] stall_cnt;
`ifdef PIPE_FORWARDING_EN
    logic [2:0] fwd_a, fwd_b;
`endif

    pipeline_hazard_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .RES_STAGE(RES)) dut (
        .clk(clk), .rst(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_wsel(dec_wsel), .dec_regwen(dec_regwen), .dec_load(dec_load),
        .redirect(redirect), .wb_halt(wb_halt), .pc_en(pc_en), .latch_en(latch_en),
        .latch_flush(latch_flush), .stall(stall), .halt(halt),
`ifdef PIPE_FORWARDING_EN
        .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
        .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    // each in-flight register writer and the latch it currently occupies
    typedef struct {int pos; logic [REG_W-1:0] w; logic ld;} wr_t;
    wr_t q[$];
    bit m_halt;
    logic [31:0] m_cnt;
    int errs = 0, checks = 0;

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic int youngest(logic [REG_W-1:0] s, logic u);
        int best = 0;
        if (u && s != 0)
            foreach (q[i])
                if (q[i].pos >= 1 && q[i].pos <= L - 2 && q[i].w == s && (best == 0 || q[i].pos < best))
                    best = q[i].pos;
        return best;
    endfunction

    function automatic bit m_frz();
        return !ihit || (mem_req && !dhit) || m_halt;
    endfunction

    function automatic bit m_haz();
        int a = youngest(dec_rs, dec_use_rs);
        int b = youngest(dec_rt, dec_use_rt);
`ifdef PIPE_FORWARDING_EN
        bit ld1 = 0;
        foreach (q[i]) if (q[i].pos == 1 && q[i].ld) ld1 = 1;
        return (a == 1 || b == 1) && ld1;
`else
        return a != 0 || b != 0;
`endif
    endfunction

    always @(posedge clk) begin
        bit stl;
        wr_t t;
        wr_t nq[$];
        if (rst) begin
            q.delete();
            m_halt = 0;
            m_cnt = 0;
        end else begin
            if (!m_frz() && !wb_halt) begin
                stl = m_haz() && !redirect;
                if (stl) m_cnt = m_cnt + 1;
                nq.delete();
                foreach (q[i])
                    if (!(redirect && q[i].pos <= RES - 2) && q[i].pos + 1 <= L - 1) begin
                        t = q[i];
                        t.pos = t.pos + 1;
                        nq.push_back(t);
                    end
                if (dec_regwen && !stl && !(redirect && RES >= 2)) begin
                    t.pos = 1;
                    t.w = dec_wsel;
                    t.ld = dec_load;
                    nq.push_back(t);
                end
                q = nq;
            end
            if (wb_halt && !m_frz()) m_halt = 1;
        end
    end

    always @(negedge clk) begin
        bit b, s;
        logic [L-1:0] ee, ef;
        b = m_frz() || wb_halt;
        s = !rst && !b && m_haz() && !redirect;
        ee = (rst || b) ? '0 : s ? L'(4'b1110) : '1;
        ef = rst ? '1 : b ? '0 : redirect ? L'((1 << RES) - 1) : s ? L'(2) : '0;
        chk("m_pc_en", pc_en, !rst && !b && !s);
        chk("m_stall", stall, s);
        chk("m_latch_en", latch_en, ee);
        chk("m_latch_flush", latch_flush, ef);
        chk("m_halt", halt, m_halt);
        chk("m_stall_cnt", stall_cnt, m_cnt);
`ifdef PIPE_FORWARDING_EN
        if (!rst) begin
            chk("m_fwd_a", fwd_a, youngest(dec_rs, dec_use_rs));
            chk("m_fwd_b", fwd_b, youngest(dec_rt, dec_use_rt));
        end
`endif
    end

    task automatic go();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ihit = 1; dhit = 1; mem_req = 0; redirect = 0; wb_halt = 0;
        dec_use_rs = 0; dec_use_rt = 0; dec_regwen = 0; dec_load = 0;
        dec_rs = 0; dec_rt = 0; dec_wsel = 0;
    endtask

    task automatic writer(logic [REG_W-1:0] w, logic ld);
        idle();
        dec_regwen = 1; dec_wsel = w; dec_load = ld;
    endtask

    task automatic dependant(logic [REG_W-1:0] s, logic [REG_W-1:0] w);
        idle();
        dec_use_rs = 1; dec_rs = s; dec_regwen = 1; dec_wsel = w;
    endtask

    initial begin
        idle();
        go();
        #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_latch_en", latch_en, 4'b0000);
        chk("rst_latch_flush", latch_flush, 4'b1111);
        chk("rst_stall", stall, 0);
        go();
        rst = 0;
        #1;
        chk("rst_halt", halt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        writer(3, 0);
        go();
        dependant(3, 4);
        for (int i = 0; i < ADD_ST; i++) begin
            #1;
            chk("raw_stall", stall, 1);
            chk("raw_bubble", latch_flush, 4'b0010);
            chk("raw_en", latch_en, 4'b1110);
            go();
        end
        #1;
        chk("raw_release", stall, 0);
        chk("raw_cnt", stall_cnt, ADD_ST);
`ifdef PIPE_FORWARDING_EN
        chk("raw_fwd", fwd_a, 1);
`endif
        go();
        idle();
        repeat (4) go();

        writer(3, 1);
        go();
        dependant(3, 6);
        redirect = 1;
        #1;
        chk("redir_pc_en", pc_en, 1);
        chk("redir_flush", latch_flush, 4'b0111);
        chk("redir_stall", stall, 0);
        go();
        idle();
        #1;
        chk("redir_cnt", stall_cnt, ADD_ST);
        repeat (4) go();

        writer(5, 1);
        go();
        dependant(5, 6);
        #1;
        chk("frz_pre_stall", stall, 1);
        mem_req = 1; dhit = 0;
        repeat (3) begin
            #1;
            chk("frz_pc_en", pc_en, 0);
            chk("frz_latch_en", latch_en, 4'b0000);
            chk("frz_stall", stall, 0);
            chk("frz_cnt", stall_cnt, ADD_ST);
            go();
        end
        mem_req = 0; dhit = 1;
        for (int i = 0; i < LD_ST; i++) begin
            #1;
            chk("lu_stall", stall, 1);
            go();
        end
        #1;
        chk("lu_release", stall, 0);
        chk("lu_cnt", stall_cnt, ADD_ST + LD_ST);
`ifdef PIPE_FORWARDING_EN
        chk("lu_fwd", fwd_a, 2);
`endif
        go();
        idle();
        repeat (4) go();

        wb_halt = 1;
        #1;
        chk("halt_same_pc_en", pc_en, 0);
        go();
        wb_halt = 0;
        #1;
        chk("halt_set", halt, 1);
        chk("halt_pc_en", pc_en, 0);
        repeat (3) go();
        #1;
        chk("halt_sticky", pc_en, 0);
        rst = 1;
        go();
        rst = 0;
        #1;
        chk("halt_clr", halt, 0);
        chk("halt_clr_pc_en", pc_en, 1);
        chk("halt_clr_cnt", stall_cnt, 0);

        repeat (3000) begin
            ihit = $urandom_range(0, 9) != 0;
            mem_req = 1'($urandom_range(0, 1));
            dhit = $urandom_range(0, 4) != 0;
            dec_rs = REG_W'($urandom_range(0, 3));
            dec_rt = REG_W'($urandom_range(0, 3));
            dec_wsel = REG_W'($urandom_range(0, 3));
            dec_use_rs = 1'($urandom_range(0, 1));
            dec_use_rt = 1'($urandom_range(0, 1));
            dec_regwen = $urandom_range(0, 9) < 7;
            dec_load = $urandom_range(0, 9) < 3;
            redirect = $urandom_range(0, 11) == 0;
            wb_halt = $urandom_range(0, 199) == 0;
            rst = m_halt && $urandom_range(0, 9) == 0;
            go();
        end
        rst = 0;
        idle();
        go();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
